// File: rtl/axis_blk_pkg.sv
// Shared types and constants for the blocking-monitored AXI-Stream port.
package axis_blk_pkg;

    localparam int unsigned STALL_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STALL,
        BLOCKED
    } blk_state_e;

endpackage

// File: rtl/axis_blk_stream_port_if.sv
// Inbound/outbound stream handshakes plus the block-monitor status bundle.
interface axis_blk_stream_port_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] d_i_TDATA;
    logic              d_i_TVALID;
    logic              d_i_TREADY;
    logic [DATA_W-1:0] d_o_TDATA;
    logic              d_o_TVALID;
    logic              d_o_TREADY;
    logic              d_i_TDATA_blk_n;
    logic              d_o_TDATA_blk_n;
    logic              block_clr;
    logic              block;
    logic [15:0]       beat_cnt;

    // slave is the port block's view; master is the surrounding kernel/bench.
    modport slave (
        input  d_i_TDATA, d_i_TVALID, d_o_TREADY, block_clr,
        output d_i_TREADY, d_o_TDATA, d_o_TVALID,
        output d_i_TDATA_blk_n, d_o_TDATA_blk_n, block, beat_cnt
    );

    modport master (
        output d_i_TDATA, d_i_TVALID, d_o_TREADY, block_clr,
        input  d_i_TREADY, d_o_TDATA, d_o_TVALID,
        input  d_i_TDATA_blk_n, d_o_TDATA_blk_n, block, beat_cnt
    );
endinterface

// File: rtl/axis_blk_fifo.sv
// Power-of-two FIFO with occupancy tracking; callers only push when not full
// and only pop when not empty.
module axis_blk_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;

    // NOTE: storage has no reset; an empty level makes stale words unreachable.
    always_ff @(posedge ap_clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);

endmodule

// File: rtl/axis_blk_stream_port.sv
// Buffered AXI-Stream pass-through that watches both ports for starvation or
// back-pressure and raises a sticky block flag after a sustained stall.
module axis_blk_stream_port
    import axis_blk_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned BLOCK_THRESH = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    axis_blk_stream_port_if.slave port
);
    localparam logic [STALL_CNT_W-1:0] THRESH = STALL_CNT_W'(BLOCK_THRESH);

    blk_state_e             state, state_nxt;
    logic [STALL_CNT_W-1:0] stall_cnt, stall_cnt_nxt;
    logic [15:0]            beat_cnt;
    logic                   ready_en;
    logic                   full, empty;
    logic                   in_ready, out_valid, push, pop;
    logic                   in_blk_n, out_blk_n, stalled, thresh_hit;

    axis_blk_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .ap_clk  (ap_clk),
        .ap_rst  (ap_rst),
        .push    (push),
        .pop     (pop),
        .wr_data (port.d_i_TDATA),
        .rd_data (port.d_o_TDATA),
        .full    (full),
        .empty   (empty)
    );

    // Holds inbound ready low through reset and for the edge that releases it.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    assign in_ready  = ready_en & ~full;
    assign out_valid = ~empty;
    assign push      = port.d_i_TVALID & in_ready;
    assign pop       = out_valid & port.d_o_TREADY;

    assign in_blk_n  = ~(in_ready & ~port.d_i_TVALID);
    assign out_blk_n = ~(out_valid & ~port.d_o_TREADY);
    assign stalled   = ~in_blk_n | ~out_blk_n;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        stall_cnt_nxt = stall_cnt;
        if (port.block_clr || !stalled) stall_cnt_nxt = '0;
        else if (stall_cnt != THRESH)   stall_cnt_nxt = stall_cnt + 1'b1;
    end

    // A clear pulse overrides a threshold reached on the same edge.
    assign thresh_hit = stalled && !port.block_clr && (stall_cnt_nxt == THRESH);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, RUN, STALL: begin
                if (thresh_hit)           state_nxt = BLOCKED;
                else if (stalled)         state_nxt = STALL;
                else if (push)            state_nxt = RUN;
                else if (empty)           state_nxt = IDLE;
                else                      state_nxt = RUN;
            end
            BLOCKED: if (port.block_clr)  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state     <= IDLE;
            stall_cnt <= '0;
            beat_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            stall_cnt <= stall_cnt_nxt;
            if (pop) beat_cnt <= beat_cnt + 1'b1;
        end
    end

    assign port.d_i_TREADY      = in_ready;
    assign port.d_o_TVALID      = out_valid;
    assign port.d_i_TDATA_blk_n = in_blk_n;
    assign port.d_o_TDATA_blk_n = out_blk_n;
    assign port.block           = (state == BLOCKED);
    assign port.beat_cnt        = beat_cnt;

endmodule

// File: tb/tb_axis_blk_stream_port.sv
// Directed bench with a data scoreboard for axis_blk_stream_port.
module tb_axis_blk_stream_port;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int THRESH = 16;

    logic ap_clk = 1'b0;
    logic ap_rst;
    always #5 ap_clk = ~ap_clk;

    axis_blk_stream_port_if #(.DATA_W(DATA_W)) bus ();

    axis_blk_stream_port #(
        .DATA_W       (DATA_W),
        .DEPTH        (DEPTH),
        .BLOCK_THRESH (THRESH)
    ) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .port   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [15:0]       exp_beats;
    bit                rdy_en_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_ready();
        return rdy_en_m && (exp_q.size() < DEPTH);
    endfunction

    // One clock: check outputs against the model, predict handshakes, advance.
    task automatic cycle();
        bit do_push, do_pop;
        logic [DATA_W-1:0] din;
        #1;
        check("tready",   bus.d_i_TREADY, exp_ready());
        check("tvalid",   bus.d_o_TVALID, exp_q.size() != 0);
        check("i_blk_n",  bus.d_i_TDATA_blk_n, !(exp_ready() && !bus.d_i_TVALID));
        check("o_blk_n",  bus.d_o_TDATA_blk_n, !((exp_q.size() != 0) && !bus.d_o_TREADY));
        check("beat_cnt", bus.beat_cnt, exp_beats);
        do_push = bus.d_i_TVALID && exp_ready();
        do_pop  = (exp_q.size() != 0) && bus.d_o_TREADY;
        if (do_pop) check("tdata", bus.d_o_TDATA, exp_q[0]);
        din = bus.d_i_TDATA;
        @(posedge ap_clk);
        #1;
        if (do_pop) begin
            void'(exp_q.pop_front());
            exp_beats++;
        end
        if (do_push) exp_q.push_back(din);
        rdy_en_m = 1'b1;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) cycle();
        check("drain_empty", bus.d_o_TVALID, 1'b0);
    endtask

    initial begin
        bus.d_i_TDATA  = '0;
        bus.d_i_TVALID = 1'b0;
        bus.d_o_TREADY = 1'b0;
        bus.block_clr  = 1'b0;
        ap_rst         = 1'b1;
        exp_beats      = '0;
        rdy_en_m       = 1'b0;

        // Reset values
        repeat (2) @(posedge ap_clk);
        #1;
        check("rst_tvalid",  bus.d_o_TVALID, 1'b0);
        check("rst_tready",  bus.d_i_TREADY, 1'b0);
        check("rst_i_blk_n", bus.d_i_TDATA_blk_n, 1'b1);
        check("rst_o_blk_n", bus.d_o_TDATA_blk_n, 1'b1);
        check("rst_block",   bus.block, 1'b0);
        check("rst_beats",   bus.beat_cnt, 16'h0);
        ap_rst = 1'b0;
        #1;
        check("ready_pre_edge", bus.d_i_TREADY, 1'b0);
        @(posedge ap_clk);
        #1;
        check("ready_first_edge", bus.d_i_TREADY, 1'b1);
        rdy_en_m = 1'b1;

        // Stream 0x01..0x08 with the sink always ready
        bus.d_o_TREADY = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.d_i_TVALID = 1'b1;
            bus.d_i_TDATA  = DATA_W'(i);
            cycle();
            if (i == 1) check("first_valid_latency", bus.d_o_TVALID, 1'b1);
        end
        bus.d_i_TVALID = 1'b0;
        drain(4);
        check("stream_beats", bus.beat_cnt, 16'd8);
        check("stream_block", bus.block, 1'b0);

        // Back-pressure: fill the FIFO, then wait out the threshold
        bus.d_o_TREADY = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.d_i_TVALID = 1'b1;
            bus.d_i_TDATA  = 32'hA1 + DATA_W'(i);
            cycle();
        end
        bus.d_i_TVALID = 1'b0;
        check("full_tready", bus.d_i_TREADY, 1'b0);
        #1;
        check("bp_o_blk_n", bus.d_o_TDATA_blk_n, 1'b0);
        for (int i = 0; i < 12; i++) begin
            cycle();
            check("bp_block_early", bus.block, 1'b0);
        end
        cycle();
        check("bp_block_16th", bus.block, 1'b1);

        // Drain from BLOCKED: flag sticks until cleared
        bus.d_o_TREADY = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            cycle();
            check("blocked_sticky", bus.block, 1'b1);
        end
        bus.block_clr = 1'b1;
        cycle();
        bus.block_clr = 1'b0;
        check("block_cleared", bus.block, 1'b0);

        // Starve 15 cycles, one beat clears the counter
        for (int i = 0; i < 15; i++) begin
            cycle();
            check("starve_block", bus.block, 1'b0);
        end
        bus.d_i_TVALID = 1'b1;
        bus.d_i_TDATA  = 32'h55;
        cycle();
        bus.d_i_TVALID = 1'b0;
        check("starve_beat_block", bus.block, 1'b0);
        for (int i = 0; i < 14; i++) begin
            cycle();
            check("starve_after_block", bus.block, 1'b0);
        end

        // Full FIFO: push attempt concurrent with pop
        bus.d_o_TREADY = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.d_i_TVALID = 1'b1;
            bus.d_i_TDATA  = 32'hB1 + DATA_W'(i);
            cycle();
        end
        bus.d_i_TDATA  = 32'hB5;
        bus.d_o_TREADY = 1'b1;
        cycle();
        bus.d_i_TVALID = 1'b0;
        check("full_pop_ready", bus.d_i_TREADY, 1'b1);
        drain(6);

        // Asynchronous reset with three entries queued
        bus.d_o_TREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.d_i_TVALID = 1'b1;
            bus.d_i_TDATA  = 32'hC1 + DATA_W'(i);
            cycle();
        end
        bus.d_i_TVALID = 1'b0;
        check("pre_rst_valid", bus.d_o_TVALID, 1'b1);
        #2;
        ap_rst = 1'b1;
        #1;
        check("async_rst_tvalid", bus.d_o_TVALID, 1'b0);
        check("async_rst_beats",  bus.beat_cnt, 16'h0);
        check("async_rst_tready", bus.d_i_TREADY, 1'b0);
        exp_q.delete();
        exp_beats = '0;
        rdy_en_m  = 1'b0;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        bus.d_o_TREADY = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        for (int i = 0; i < 2; i++) begin
            bus.d_i_TVALID = 1'b1;
            bus.d_i_TDATA  = 32'hD1 + DATA_W'(i);
            cycle();
        end
        bus.d_i_TVALID = 1'b0;
        drain(4);
        check("post_rst_beats", bus.beat_cnt, 16'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
